spi_regfile_rw: RTL and testbench

SPI_REGFILE_RW -- requirements
Module: spi_regfile_rw

---
 rtl/spi_regfile_rw.sv | 157 +++++++++++++++
 tb/tb_spi_regfile_rw.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/spi_regfile_rw.sv
// SPI mode-0 peripheral with a small register file: write frames load a register on nCS release,
// read frames stream a shadow copy of the addressed register back on CIPO.
module spi_regfile_rw #(
    parameter int NUM_REGS = 5,
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 7
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sCLK,
    input  logic                       nCS,
    input  logic                       COPI,
    output logic                       CIPO,
    output logic                       cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs_out,
    output logic                       wr_strobe,
    output logic [ADDR_W-1:0]          wr_addr
);

    localparam int FL    = 1 + ADDR_W + DATA_W;
    localparam int CNT_W = $clog2(FL + 1);

    logic              sclk_s1, sclk_s2, sclk_d;
    logic              ncs_s1, ncs_s2, ncs_d;
    logic              copi_s1, copi_s2;
    logic [CNT_W-1:0]  bit_cnt;
    logic              overrun;
    logic              shadow_load;
    logic              read_active;
    logic [FL-1:0]     frame_sr;
    logic [DATA_W-1:0] shadow;
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] rd_val;

    logic              sclk_rise, sclk_fall, ncs_rise, ncs_fall;
    logic              c_rw;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_data;
    logic              commit_ok;
    logic              in_data_phase;

    assign sclk_rise = sclk_s2 & ~sclk_d;
    assign sclk_fall = ~sclk_s2 & sclk_d;
    assign ncs_rise  = ncs_s2 & ~ncs_d;
    assign ncs_fall  = ~ncs_s2 & ncs_d;

    // Fields are only meaningful once a full frame has been shifted in.
    assign c_rw      = frame_sr[FL-1];
    assign c_addr    = frame_sr[DATA_W +: ADDR_W];
    assign c_data    = frame_sr[DATA_W-1:0];
    assign commit_ok = (bit_cnt == CNT_W'(FL)) && !overrun && c_rw && (32'(c_addr) < NUM_REGS);

    assign in_data_phase = read_active && (bit_cnt >= CNT_W'(1 + ADDR_W)) && (bit_cnt <= CNT_W'(FL - 1));

    // Mid-frame the address sits in the low bits of the shift register; unmapped addresses read as zero.
    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ADDR_W'(i) == frame_sr[ADDR_W-1:0]) rd_val = regs[i];
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
        assign regs_out[g*DATA_W +: DATA_W] = regs[g];
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_s1     <= 1'b0;
            sclk_s2     <= 1'b0;
            sclk_d      <= 1'b0;
            ncs_s1      <= 1'b1;
            ncs_s2      <= 1'b1;
            ncs_d       <= 1'b1;
            copi_s1     <= 1'b0;
            copi_s2     <= 1'b0;
            bit_cnt     <= '0;
            overrun     <= 1'b0;
            shadow_load <= 1'b0;
            read_active <= 1'b0;
            frame_sr    <= '0;
            shadow      <= '0;
            CIPO        <= 1'b0;
            cipo_oe     <= 1'b0;
            wr_strobe   <= 1'b0;
            wr_addr     <= '0;
            // NOTE: the register file is small and must read back zero after reset, so it is reset explicitly.
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            sclk_s1   <= sCLK;
            sclk_s2   <= sclk_s1;
            sclk_d    <= sclk_s2;
            ncs_s1    <= nCS;
            ncs_s2    <= ncs_s1;
            ncs_d     <= ncs_s2;
            copi_s1   <= COPI;
            copi_s2   <= copi_s1;
            wr_strobe <= 1'b0;
            cipo_oe   <= ~ncs_s2;

            if (shadow_load) begin
                shadow_load <= 1'b0;
                if (!frame_sr[ADDR_W]) begin
                    read_active <= 1'b1;
                    shadow      <= rd_val;
                end
            end

            if (!ncs_s2) begin
                if (sclk_rise) begin
                    if (bit_cnt == CNT_W'(FL)) begin
                        overrun <= 1'b1;
                    end else begin
                        frame_sr <= {frame_sr[FL-2:0], copi_s2};
                        bit_cnt  <= bit_cnt + 1'b1;
                        if (bit_cnt == CNT_W'(ADDR_W)) shadow_load <= 1'b1;
                    end
                end
                if (sclk_fall) begin
                    if (in_data_phase) begin
                        CIPO   <= shadow[DATA_W-1];
                        shadow <= {shadow[DATA_W-2:0], 1'b0};
                    end else begin
                        CIPO <= 1'b0;
                    end
                end
            end else begin
                CIPO <= 1'b0;
            end

            // Commit precedes the frame-start clear so back-to-back frames are both honoured.
            if (ncs_rise) begin
                if (commit_ok) begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (ADDR_W'(i) == c_addr) regs[i] <= c_data;
                    end
                    wr_strobe <= 1'b1;
                    wr_addr   <= c_addr;
                end
                read_active <= 1'b0;
                shadow_load <= 1'b0;
            end

            if (ncs_fall) begin
                bit_cnt     <= '0;
                overrun     <= 1'b0;
                frame_sr    <= '0;
                shadow      <= '0;
                shadow_load <= 1'b0;
                read_active <= 1'b0;
                CIPO        <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_regfile_rw.sv
// Directed bench for spi_regfile_rw: default build plus a 16x16 build sharing the same SPI wires.
module tb_spi_regfile_rw;

    localparam int T_HALF = 60;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         sCLK = 1'b0;
    logic         nCS = 1'b1;
    logic         COPI = 1'b0;

    logic         CIPO, cipo_oe, wr_strobe;
    logic [39:0]  regs_out;
    logic [6:0]   wr_addr;

    logic         CIPO16, cipo_oe16, wr_strobe16;
    logic [255:0] regs_out16;
    logic [6:0]   wr_addr16;

    int total = 0;
    int bad   = 0;
    int strobes = 0;
    int strobes16 = 0;
    int s0;
    logic [31:0] cap, cap16;
    logic        oe_seen;

    spi_regfile_rw dut (
        .clk(clk), .rst(rst), .sCLK(sCLK), .nCS(nCS), .COPI(COPI),
        .CIPO(CIPO), .cipo_oe(cipo_oe), .regs_out(regs_out),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr)
    );

    spi_regfile_rw #(.NUM_REGS(16), .DATA_W(16), .ADDR_W(7)) dut16 (
        .clk(clk), .rst(rst), .sCLK(sCLK), .nCS(nCS), .COPI(COPI),
        .CIPO(CIPO16), .cipo_oe(cipo_oe16), .regs_out(regs_out16),
        .wr_strobe(wr_strobe16), .wr_addr(wr_addr16)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wr_strobe) strobes <= strobes + 1;
        if (wr_strobe16) strobes16 <= strobes16 + 1;
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sends nbits of 'bits' MSB first; abort_at >= 0 pulses rst before that bit index.
    task automatic frame(input logic [31:0] bits, input int nbits, input int abort_at);
        nCS = 1'b0;
        #T_HALF;
        oe_seen = cipo_oe;
        for (int k = nbits - 1; k >= 0; k--) begin
            if (abort_at >= 0 && (nbits - 1 - k) == abort_at) begin
                rst = 1'b1;
                #30;
                rst = 1'b0;
                #T_HALF;
            end
            COPI = bits[k];
            #T_HALF;
            sCLK  = 1'b1;
            cap   = {cap[30:0], CIPO};
            cap16 = {cap16[30:0], CIPO16};
            #T_HALF;
            sCLK = 1'b0;
        end
        #T_HALF;
        nCS  = 1'b1;
        COPI = 1'b0;
        #(4 * T_HALF);
    endtask

    initial begin
        cap = '0;
        cap16 = '0;
        #50;
        check("rst_regs", 256'(regs_out), 256'h0);
        check("rst_strobe", 256'(wr_strobe), 256'h0);
        check("rst_wr_addr", 256'(wr_addr), 256'h0);
        check("rst_cipo", 256'(CIPO), 256'h0);
        check("rst_oe", 256'(cipo_oe), 256'h0);
        rst = 1'b0;
        #40;

        s0 = strobes;
        frame({16'h0, 1'b1, 7'h02, 8'hA5}, 16, -1);
        check("wr_oe_during_frame", 256'(oe_seen), 256'h1);
        check("wr_regs", 256'(regs_out), 256'h00_00_A5_00_00);
        check("wr_strobe_count", 256'(strobes - s0), 256'h1);
        check("wr_addr", 256'(wr_addr), 256'h02);
        check("idle_oe", 256'(cipo_oe), 256'h0);

        s0 = strobes;
        frame({16'h0, 1'b0, 7'h02, 8'h00}, 16, -1);
        check("rd_data", 256'(cap[7:0]), 256'hA5);
        check("rd_no_change", 256'(regs_out), 256'h00_00_A5_00_00);
        check("rd_no_strobe", 256'(strobes - s0), 256'h0);
        check("rd_idle_cipo", 256'(CIPO), 256'h0);

        s0 = strobes;
        frame({16'h0, 1'b1, 7'h05, 8'h11}, 16, -1);
        frame({16'h0, 1'b1, 7'h7F, 8'h22}, 16, -1);
        check("wr_oob_regs", 256'(regs_out), 256'h00_00_A5_00_00);
        check("wr_oob_no_strobe", 256'(strobes - s0), 256'h0);
        cap = 32'hFFFF_FFFF;
        frame({16'h0, 1'b0, 7'h05, 8'h00}, 16, -1);
        check("rd_oob_zero", 256'(cap[7:0]), 256'h00);

        s0 = strobes;
        frame({17'h0, 1'b1, 7'h00, 7'h7F}, 15, -1);
        frame({15'h0, 1'b1, 7'h00, 8'hFF, 1'b1}, 17, -1);
        check("short_long_regs", 256'(regs_out), 256'h00_00_A5_00_00);
        check("short_long_no_strobe", 256'(strobes - s0), 256'h0);

        s0 = strobes;
        frame({16'h0, 1'b1, 7'h01, 8'h77}, 16, 10);
        frame({16'h0, 1'b1, 7'h04, 8'h3C}, 16, -1);
        check("abort_regs", 256'(regs_out), 256'h3C_00_00_00_00);
        check("abort_strobe_count", 256'(strobes - s0), 256'h1);
        check("abort_wr_addr", 256'(wr_addr), 256'h04);

        s0 = strobes16;
        frame({8'h0, 1'b1, 7'h0F, 16'hBEEF}, 24, -1);
        check("w16_regs", regs_out16, {16'hBEEF, 240'h0});
        check("w16_strobe_count", 256'(strobes16 - s0), 256'h1);
        check("w16_wr_addr", 256'(wr_addr16), 256'h0F);
        check("w16_default_untouched", 256'(regs_out), 256'h3C_00_00_00_00);
        frame({8'h0, 1'b0, 7'h0F, 16'h0000}, 24, -1);
        check("r16_data", 256'(cap16[15:0]), 256'hBEEF);
        check("r16_no_change", regs_out16, {16'hBEEF, 240'h0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
